// File: rtl/bcd_pkg.sv
// Shared constants for the packed-BCD to binary converter.
// Latency: n/a (constants and type definitions only).
// Backpressure: n/a.
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_ADJ        = 4'd3;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/response bundle for the sequential BCD to binary converter.
// Latency: n/a (wiring only).
// Backpressure: none; start is ignored while busy, with no queueing.
// master drives start/bcd_in and receives busy/done/err/bin; slave is the converter.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin;

  modport master (output start, bcd_in, input busy, done, err, bin);
  modport slave  (input start, bcd_in, output busy, done, err, bin);
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction for reverse double-dabble: digits >= 8 lose 3.
// Latency: combinational.
// Backpressure: n/a.
// Ports: din (4-bit digit after the shift), dout (corrected digit).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit that is >= 8 after a right shift held a "10s" carry from the digit
  // above worth 8 instead of 5, so pull it back by 3.
  assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to binary converter, one reverse double-dabble step per clock.
// Latency: done BIN_W edges after the accept edge; invalid digit -> done at the accept edge.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clk, rst_n (async, active-low), bus (slave: start, bcd_in -> busy, done, err, bin).
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int SREG_W = 4*DIGITS + BIN_W;
  localparam logic [BIN_W-1:0] CNT_LAST = BIN_W'(BIN_W - 1);

  state_e              state, state_nxt;
  logic [SREG_W-1:0]   sreg, sreg_nxt;
  logic [BIN_W-1:0]    cnt, cnt_nxt;
  logic [BIN_W-1:0]    bin_q, bin_nxt;
  logic                done_q, done_nxt;
  logic                err_q, err_nxt;

  logic [SREG_W-1:0]   shifted;
  logic [4*DIGITS-1:0] adj_digits;
  logic [SREG_W-1:0]   stepped;
  logic                bad_digit;

  // BCD digits live above the binary field; bits shifted out of the ones digit
  // accumulate the binary result from the top of the low field downwards.
  assign shifted = sreg >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shifted[BIN_W + 4*g +: 4]),
      .dout (adj_digits[4*g +: 4])
    );
  end

  assign stepped = {adj_digits, shifted[BIN_W-1:0]};

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    bin_nxt   = bin_q;
    err_nxt   = err_q;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bad_digit) begin
            // Rejected without converting: report straight away and stay idle.
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
            bin_nxt  = '0;
          end else begin
            sreg_nxt  = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        sreg_nxt = stepped;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          bin_nxt   = stepped[BIN_W-1:0];
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sreg   <= '0;
      cnt    <= '0;
      bin_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      bin_q  <= bin_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.busy = (state == ST_SHIFT);
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (4 digits, 14-bit result).
// Inputs change and outputs are sampled on the falling clock edge.
// Latencies are counted in rising edges from the cycle start is raised.
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  logic rst_n;

  int n_total = 0;
  int n_pass  = 0;

  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Issue one request at a falling edge and watch the outputs for a bounded window.
  // poke_k > 0 pulses start with 9999 at that cycle to probe the busy-time drop.
  task automatic convert(input logic [15:0] v, input int poke_k,
                         output int lat, output int busy_n, output int dones,
                         output logic [13:0] bin_o, output logic err_o);
    bus.bcd_in = v;
    bus.start  = 1'b1;
    lat = -1; busy_n = 0; dones = 0; bin_o = '0; err_o = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (poke_k > 0 && k == poke_k) begin
        bus.start  = 1'b1;
        bus.bcd_in = 16'h9999;
      end
      if (poke_k > 0 && k == poke_k + 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat   = k;
          bin_o = bus.bin;
          err_o = bus.err;
        end
      end
      if (lat >= 0 && k >= lat + 3) break;
    end
  endtask

  int          lat, busy_n, dones;
  logic [13:0] bin_r;
  logic        err_r;
  int          done1, done2;
  logic [13:0] bin1, bin2;
  logic        busy_gap;

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;

    // 1. reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_busy", 32'(bus.busy), 0);
    check("rel_done", 32'(bus.done), 0);
    check("rel_err",  32'(bus.err),  0);
    check("rel_bin",  32'(bus.bin),  0);

    // 2. edge values: accept edge + 14 shift edges
    convert(16'h0000, 0, lat, busy_n, dones, bin_r, err_r);
    check("z_lat",   32'(lat),    15);
    check("z_bin",   32'(bin_r),  0);
    check("z_err",   32'(err_r),  0);
    check("z_busy",  32'(busy_n), 14);
    check("z_dones", 32'(dones),  1);
    convert(16'h9999, 0, lat, busy_n, dones, bin_r, err_r);
    check("n_lat",   32'(lat),    15);
    check("n_bin",   32'(bin_r),  32'd9999);

    // 3. back-to-back: start held through the first done cycle
    bus.bcd_in = 16'h1234;
    bus.start  = 1'b1;
    done1 = -1; done2 = -1; busy_n = 0; dones = 0; busy_gap = 1'b0;
    bin1 = '0; bin2 = '0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1)  bus.bcd_in = 16'h8191;
      if (k == 16) bus.start  = 1'b0;
      if (bus.busy) busy_n++;
      if (k == 15) busy_gap = bus.busy;
      if (bus.done) begin
        dones++;
        if (done1 < 0) begin done1 = k; bin1 = bus.bin; end
        else if (done2 < 0) begin done2 = k; bin2 = bus.bin; end
      end
    end
    check("b1_lat",   32'(done1),    15);
    check("b1_bin",   32'(bin1),     32'h04D2);
    check("b2_lat",   32'(done2),    30);
    check("b2_bin",   32'(bin2),     32'h1FFF);
    check("bb_busy",  32'(busy_n),   28);
    check("bb_gap",   32'(busy_gap), 0);
    check("bb_dones", 32'(dones),    2);

    // 4. invalid digit, then a clean request clears err
    convert(16'h12A4, 0, lat, busy_n, dones, bin_r, err_r);
    check("inv_lat",   32'(lat),    1);
    check("inv_err",   32'(err_r),  1);
    check("inv_bin",   32'(bin_r),  0);
    check("inv_busy",  32'(busy_n), 0);
    check("inv_dones", 32'(dones),  1);
    check("inv_hold",  32'(bus.err), 1);
    convert(16'h0042, 0, lat, busy_n, dones, bin_r, err_r);
    check("v42_err", 32'(err_r), 0);
    check("v42_bin", 32'(bin_r), 32'd42);

    // 5. start during a conversion is dropped
    convert(16'h0500, 5, lat, busy_n, dones, bin_r, err_r);
    check("ign_lat",   32'(lat),   15);
    check("ign_bin",   32'(bin_r), 32'd500);
    check("ign_dones", 32'(dones), 1);

    // 6. reset mid-conversion aborts without a done
    bus.bcd_in = 16'h1234;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_done", 32'(bus.done), 0);
    check("ab_err",  32'(bus.err),  0);
    check("ab_bin",  32'(bus.bin),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("ab_nodone", 32'(dones), 0);
    convert(16'h0007, 0, lat, busy_n, dones, bin_r, err_r);
    check("v7_lat", 32'(lat),   15);
    check("v7_bin", 32'(bin_r), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
